ntt_twiddle_sequencer: RTL and testbench

//  Drives start/switch/data_loop of the twiddle ROM through one full NTT: pass 0 uses the initial set (switch=0), then passes 1..19 use data_loop 6'h15..6'h27.
//  For each pass it loads the twiddle set, waits for ROM latency, then does a req/ack handshake with the butterfly array. Sits between the top-level polynomial-multiply FSM and the twiddle ROM / butterfly bank.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/ntt_twiddle_sequencer_watchdog.sv | 30 +++
 rtl/ntt_twiddle_sequencer.sv | 152 +++++++++++++++
 tb/tb_ntt_twiddle_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT twiddle sequencing logic.
// The optional ack watchdog is enabled with the NTT_SEQ_TIMEOUT_EN macro.
package ntt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      REQ  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   localparam logic [5:0] NTT_LOOP_FIRST = 6'h15;
   localparam logic [5:0] NTT_LOOP_LAST  = 6'h27;
   localparam int         NTT_NUM_PASSES = 20;
   localparam int         TW_W           = 16;

endpackage

// File: rtl/ntt_twiddle_sequencer_watchdog.sv
// Ack watchdog for the twiddle sequencer. Built only when NTT_SEQ_TIMEOUT_EN is defined.
// The count is held at zero outside REQ, so it restarts on every REQ entry.
module ntt_seq_watchdog #(
   parameter int TO_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TO_CYC + 1);

   logic [CW-1:0] cnt;

   // Count REQ cycles; expired marks the edge at which TO_CYC cycles have gone by without ack
   assign expired = run && (cnt == CW'(TO_CYC - 1));

   // Cycle counter, cleared whenever the sequencer is not waiting in REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ntt_twiddle_sequencer.sv
// Steps the twiddle ROM through the passes of one NTT and handshakes each pass
// with the butterfly bank. Pass 0 uses the initial set (switch=0); later passes
// index the ROM with data_loop = LOOP_FIRST..LOOP_LAST.
// Optional feature: NTT_SEQ_TIMEOUT_EN adds an ack watchdog that sets the sticky err flag.
//
// Handshake: bfly_req rises on the first REQ cycle and stays high until bfly_ack is
// sampled high on a rising clk edge while bfly_req=1; ack at any other time is ignored.
module ntt_twiddle_sequencer
   import ntt_pkg::*;
#(
   parameter logic [5:0] LOOP_FIRST = NTT_LOOP_FIRST,
   parameter logic [5:0] LOOP_LAST  = NTT_LOOP_LAST,
   parameter int         ROM_LAT    = 1,
   parameter int         TO_CYC     = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       abort,
   input  logic       bfly_ack,
   output logic       start,
   output logic       switch,
   output logic [5:0] data_loop,
   output logic       bfly_req,
   output logic [4:0] pass_idx,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] dbg_state
);

   localparam int               LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

   seq_state_t       state, state_n;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
   logic             switch_n;
   logic [5:0]       data_loop_n;
   logic [4:0]       pass_idx_n;
   logic             wd_expired;

   assign dbg_state = state;

`ifdef NTT_SEQ_TIMEOUT_EN
   ntt_seq_watchdog #(
      .TO_CYC (TO_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state == REQ),
      .expired (wd_expired)
   );

   // Sticky timeout flag: set when REQ times out, cleared by an accepted go; abort leaves it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (!abort) begin
         if (state == IDLE && go) begin
            err <= 1'b0;
         end else if (state == REQ && !bfly_ack && wd_expired) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   // Next state and next selector values; abort overrides everything else
   always_comb begin
      state_n     = state;
      lat_cnt_n   = lat_cnt;
      switch_n    = switch;
      data_loop_n = data_loop;
      pass_idx_n  = pass_idx;
      if (abort) begin
         state_n    = IDLE;
         pass_idx_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state_n     = LOAD;
                  lat_cnt_n   = '0;
                  pass_idx_n  = '0;
                  switch_n    = 1'b0;
                  data_loop_n = 6'h00;
               end
            end
            LOAD: begin
               if (lat_cnt == LAT_LAST) begin
                  state_n = REQ;
               end else begin
                  lat_cnt_n = lat_cnt + 1'b1;
               end
            end
            REQ: begin
               if (bfly_ack) begin
                  if (switch && data_loop == LOOP_LAST) begin
                     state_n = DONE;
                  end else begin
                     state_n     = LOAD;
                     lat_cnt_n   = '0;
                     pass_idx_n  = pass_idx + 5'd1;
                     switch_n    = 1'b1;
                     data_loop_n = (pass_idx == 5'd0) ? LOOP_FIRST : data_loop + 6'd1;
                  end
               end else if (wd_expired) begin
                  state_n    = IDLE;
                  pass_idx_n = '0;
               end
            end
            DONE: begin
               state_n    = IDLE;
               pass_idx_n = '0;
            end
            default: begin
               state_n    = IDLE;
               pass_idx_n = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         start     <= 1'b1;
         switch    <= 1'b0;
         data_loop <= 6'h00;
         bfly_req  <= 1'b0;
         pass_idx  <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         lat_cnt   <= lat_cnt_n;
         start     <= (state_n == IDLE) || (state_n == DONE);
         switch    <= switch_n;
         data_loop <= data_loop_n;
         bfly_req  <= (state_n == REQ);
         pass_idx  <= pass_idx_n;
         busy      <= (state_n != IDLE);
         done      <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Bench for ntt_twiddle_sequencer. Two instances (ROM_LAT=1 and ROM_LAT=3) share
// clk/rst_n. Each run is planned as a pass timeline (LOAD/REQ spans from the
// ROM latency and per-pass ack waits); the plan yields per-cycle stimulus and
// expected outputs that are compared cycle by cycle.
module tb_ntt_twiddle_sequencer;

   localparam int         NP = 20;
   localparam logic [5:0] LF = 6'h15;
   localparam logic [5:0] LL = 6'h27;
   localparam int         TO = 16;
   localparam int         W  = 17;

   typedef struct {
      int d;
      int w;
      int abort_slot;
      int to_pass;
      int noise_go;
      int noise_ack;
      int exp_done_edge;
   } scen_t;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       go_s[2], abort_s[2], ack_s[2];
   logic       start_o[2], switch_o[2], req_o[2], busy_o[2], done_o[2], err_o[2];
   logic [5:0] loop_o[2];
   logic [4:0] pidx_o[2];
   logic [1:0] st_o[2];

   ntt_twiddle_sequencer #(.ROM_LAT(1), .TO_CYC(TO)) dut0 (
      .clk(clk), .rst_n(rst_n), .go(go_s[0]), .abort(abort_s[0]), .bfly_ack(ack_s[0]),
      .start(start_o[0]), .switch(switch_o[0]), .data_loop(loop_o[0]), .bfly_req(req_o[0]),
      .pass_idx(pidx_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
      .dbg_state(st_o[0])
   );

   ntt_twiddle_sequencer #(.ROM_LAT(3), .TO_CYC(TO)) dut1 (
      .clk(clk), .rst_n(rst_n), .go(go_s[1]), .abort(abort_s[1]), .bfly_ack(ack_s[1]),
      .start(start_o[1]), .switch(switch_o[1]), .data_loop(loop_o[1]), .bfly_req(req_o[1]),
      .pass_idx(pidx_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
      .dbg_state(st_o[1])
   );

   // scoreboard
   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   logic [2:0]   stim_q[$];

   // reference-model state (held selector values and err between runs)
   int          lat_of[2];
   logic        m_sw[2];
   logic [5:0]  m_lp[2];
   logic        m_err[2];
   int          exp_rises, exp_dones;
   int          last_done_edge;
   int          wv[NP];
   scen_t       tbl[8];

   function automatic logic [W-1:0] pack(input logic st, input logic sw, input logic [5:0] lp,
                                         input logic rq, input logic [4:0] pi, input logic bz,
                                         input logic dn, input logic er);
      return {st, sw, lp, rq, pi, bz, dn, er};
   endfunction

   function automatic logic [W-1:0] get_out(input int d);
      return pack(start_o[d], switch_o[d], loop_o[d], req_o[d], pidx_o[d], busy_o[d], done_o[d], err_o[d]);
   endfunction

   function automatic logic [5:0] loop_of(input int p);
      logic [5:0] v;
      v = (p > 0) ? 6'(int'(LF) + p - 1) : 6'h00;
      return v;
   endfunction

   task automatic check_word(input string name, input logic [W-1:0] got,
                             input logic [W-1:0] exp, input logic [W-1:0] msk);
      checks++;
      if ((got & msk) !== (exp & msk)) begin
         errors++;
         $display("FAIL %s: got %h expected %h (mask %h) [st sw loop req pidx busy done err]",
                  name, got, exp, msk);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Plan one run: go at slot 0; slot i checks outputs after edge i-1 and drives inputs for edge i.
   // abort_slot -2 picks a random abort (or none).
   task automatic plan(input int d, input int abort_slot, input int to_pass,
                       input int noise_go, input int noise_ack);
      int lat, x, n, px, e, p, ab;
      int t[NP+1];
      logic g, a, k, inreq;
      logic [W-1:0] ev, mv;
      lat  = lat_of[d];
      t[0] = 0;
      for (int q = 0; q < NP; q++) begin
         if (q == to_pass) t[q+1] = t[q] + lat + TO + 100;
         else              t[q+1] = t[q] + lat + wv[q] + 1;
      end
      ab = abort_slot;
      if (ab == -2) ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t[NP])) : -1;
      x = ab;
      if (x < 0 && to_pass >= 0) x = t[to_pass] + lat + TO;
      n  = (x >= 0) ? x + 4 : t[NP] + 5;
      px = 0;
      if (x > 0) begin
         for (int q = 0; q < NP; q++) if (t[q] <= x - 1) px = q;
      end
      exp_rises = 0;
      for (int q = 0; q < NP; q++) if (x < 0 || t[q] + lat < x) exp_rises++;
      exp_dones = (x < 0) ? 1 : 0;
      for (int i = 0; i < n; i++) begin
         g = (i == 0) || (i == noise_go);
         a = (i == ab);
         k = (i == noise_ack);
         for (int q = 0; q < NP; q++) if (i == t[q+1] && (x < 0 || i <= x)) k = 1'b1;
         e = i - 1;
         if (i == 0 || x == 0) begin
            ev = pack(1'b1, m_sw[d], m_lp[d], 1'b0, 5'd0, 1'b0, 1'b0, m_err[d]);
         end else if (x > 0 && e >= x) begin
            ev = pack(1'b1, px > 0, loop_of(px), 1'b0, 5'd0, 1'b0, 1'b0, to_pass >= 0);
         end else if (e >= t[NP]) begin
            if (e == t[NP]) ev = pack(1'b1, 1'b1, LL, 1'b0, 5'(NP - 1), 1'b1, 1'b1, 1'b0);
            else            ev = pack(1'b1, 1'b1, LL, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
         end else begin
            p = 0;
            for (int q = 0; q < NP; q++) if (t[q] <= e) p = q;
            inreq = (e >= t[p] + lat);
            ev = pack(1'b0, p > 0, loop_of(p), inreq, 5'(p), 1'b1, 1'b0, 1'b0);
         end
         mv = '1;
         if (ev[15] == 1'b0) mv[14:9] = 6'h00;
         exp_q.push_back(ev);
         msk_q.push_back(mv);
         stim_q.push_back({g, a, k});
      end
      if (x < 0) begin
         m_sw[d] = 1'b1; m_lp[d] = LL; m_err[d] = 1'b0;
      end else if (x > 0) begin
         m_sw[d] = (px > 0);
         if (px > 0) m_lp[d] = loop_of(px);
         m_err[d] = (to_pass >= 0);
      end
   endtask

   // driver + comparison; stop >= 0 abandons the run after that many slots
   task automatic run_plan(input int d, input int stop);
      int i, rises, dones, dslot;
      logic prev_req;
      logic [W-1:0] ev, mv;
      logic [2:0] s;
      i = 0; rises = 0; dones = 0; dslot = -1; prev_req = 1'b0;
      while (exp_q.size() > 0 && (stop < 0 || i < stop)) begin
         @(negedge clk);
         ev = exp_q.pop_front();
         mv = msk_q.pop_front();
         s  = stim_q.pop_front();
         check_word($sformatf("dut%0d slot%0d", d, i), get_out(d), ev, mv);
         if (req_o[d] && !prev_req) rises++;
         prev_req = req_o[d];
         if (done_o[d]) begin
            dones++;
            if (dslot < 0) dslot = i;
         end
         go_s[d]    = s[2];
         abort_s[d] = s[1];
         ack_s[d]   = s[0];
         i++;
      end
      last_done_edge = (dslot >= 0) ? dslot - 1 : -1;
      if (stop < 0) begin
         check_int($sformatf("dut%0d req_pulses", d), rises, exp_rises);
         check_int($sformatf("dut%0d done_pulses", d), dones, exp_dones);
      end
      exp_q.delete();
      msk_q.delete();
      stim_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_word($sformatf("%s dut%0d outputs", tag, d), get_out(d),
                    pack(1'b1, 1'b0, 6'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), '1);
         check_int($sformatf("%s dut%0d state", tag, d), int'(st_o[d]), 0);
      end
   endtask

   initial begin
      lat_of[0] = 1;
      lat_of[1] = 3;
      for (int d = 0; d < 2; d++) begin
         go_s[d] = 1'b0; abort_s[d] = 1'b0; ack_s[d] = 1'b0;
         m_sw[d] = 1'b0; m_lp[d] = 6'h00; m_err[d] = 1'b0;
      end
      //             d  w  abort to  ngo nack done_edge
      tbl[0] = '{0, 0, -1, -1, -1, -1, 40};   // ack in first REQ cycle
      tbl[1] = '{0, 1, -1, -1, -1, -1, 60};   // 3 cycles per pass
      tbl[2] = '{1, 5, -1, -1, -1, -1, 180};  // ROM_LAT=3, ack 5 cycles late
      tbl[3] = '{0, 2, 31, -1, -1, -1, -1};   // abort during pass 7 REQ
      tbl[4] = '{0, 0, -1, -1, -1, -1, 40};   // restart after abort
      tbl[5] = '{0, 0, 0, -1, -1, -1, -1};    // go and abort together in IDLE
      tbl[6] = '{0, 0, -1, -1, 9, 13, 40};    // go in pass 4, ack in LOAD
      tbl[7] = '{1, 0, -1, -1, 20, 10, 80};   // same on ROM_LAT=3

      // reset block
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("post_reset");

      // directed scenario table
      for (int s = 0; s < 8; s++) begin
         for (int q = 0; q < NP; q++) wv[q] = tbl[s].w;
         plan(tbl[s].d, tbl[s].abort_slot, tbl[s].to_pass, tbl[s].noise_go, tbl[s].noise_ack);
         run_plan(tbl[s].d, -1);
         check_int($sformatf("scen%0d done_edge", s), last_done_edge, tbl[s].exp_done_edge);
      end

      // asynchronous reset in the middle of pass 12
      for (int q = 0; q < NP; q++) wv[q] = 0;
      plan(0, -1, -1, -1, -1);
      run_plan(0, 26);
      check_int("pre_reset pass_idx", int'(pidx_o[0]), 12);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      for (int d = 0; d < 2; d++) begin
         go_s[d] = 1'b0; abort_s[d] = 1'b0; ack_s[d] = 1'b0;
         m_sw[d] = 1'b0; m_lp[d] = 6'h00; m_err[d] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;

      // randomized runs against the pass-timeline model
      for (int r = 0; r < 12; r++) begin
         int d;
         d = int'($urandom_range(0, 1));
         for (int q = 0; q < NP; q++) wv[q] = int'($urandom_range(0, 6));
         plan(d, -2, -1, -1, -1);
         run_plan(d, -1);
      end

`ifdef NTT_SEQ_TIMEOUT_EN
      // no ack on pass 2: timeout to IDLE with err, then err clears on the next go
      for (int q = 0; q < NP; q++) wv[q] = 0;
      plan(0, -1, 2, -1, -1);
      run_plan(0, -1);
      check_int("timeout err", int'(err_o[0]), 1);
      plan(0, -1, -1, -1, -1);
      run_plan(0, -1);
      check_int("err cleared", int'(err_o[0]), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
